// File: rtl/axi_mem_arb.sv
// axi_mem_arb: round-robin arbiter sharing one single-port SRAM channel between NREQ requesters.
// One grant per cycle. Read data comes back one cycle after the grant and is steered to the
// requester that issued the read.
// Optional grant locking is compiled in when AXI_MEM_ARB_LOCK_EN is defined.
module axi_mem_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAW      = 29,
  parameter int unsigned DW       = 64,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_we,
  input  logic [NREQ*MAW-1:0] req_addr,
  input  logic [NREQ*DW-1:0]  req_wdata,
  input  logic [NREQ-1:0]     req_lock,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [DW-1:0]       rsp_rdata,
  output logic                mem_cs,
  output logic                mem_we,
  output logic [MAW-1:0]      mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata
);

  localparam int unsigned PW = $clog2(NREQ);

  logic            en_q;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] rd_q, rd_d;
  logic [PW-1:0]   rr_win, win, idx;
  logic            found, accept, lock_take;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return PW'((32'(i) + 32'd1) % NREQ);
  endfunction

  // Round-robin scan starting at ptr_q.
  always_comb begin
    rr_win = ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PW'((32'(ptr_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        rr_win = idx;
      end
    end
  end

`ifdef AXI_MEM_ARB_LOCK_EN
  logic          lock_act_q, lock_act_d;
  logic [PW-1:0] lock_own_q, lock_own_d;
  logic [7:0]    lock_cnt_q, lock_cnt_d;
  logic          lock_free;

  assign lock_take = lock_act_q && req_valid[lock_own_q];
`else
  logic unused_lock;
  localparam int unsigned unused_max_lock = MAX_LOCK;

  assign unused_lock = ^req_lock;
  assign lock_take   = 1'b0;
`endif

  // Grant selection and SRAM request mux; everything is held off until en_q.
  always_comb begin
    win       = lock_take ? idx_own() : rr_win;
    accept    = en_q && (|req_valid);
    req_ready = accept ? (NREQ'(1) << win) : '0;
    mem_cs    = accept;
    mem_we    = accept && req_we[win];
    mem_addr  = accept ? req_addr[32'(win) * MAW +: MAW] : '0;
    mem_wdata = accept ? req_wdata[32'(win) * DW +: DW] : '0;
    rd_d      = (accept && !req_we[win]) ? req_ready : '0;
  end

  function automatic logic [PW-1:0] idx_own();
`ifdef AXI_MEM_ARB_LOCK_EN
    return lock_own_q;
`else
    return '0;
`endif
  endfunction

  // Pointer update, plus lock bookkeeping when locking is compiled in.
  always_comb begin
    ptr_d = ptr_q;
`ifdef AXI_MEM_ARB_LOCK_EN
    lock_act_d = lock_act_q;
    lock_own_d = lock_own_q;
    lock_cnt_d = lock_cnt_q;
    lock_free  = 1'b1;
    if (lock_act_q) begin
      if (lock_take) begin
        lock_free = 1'b0;
        if (req_lock[lock_own_q] && (32'(lock_cnt_q) + 32'd1 < MAX_LOCK)) begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end else begin
          lock_act_d = 1'b0;
          lock_cnt_d = '0;
          ptr_d      = next_idx(lock_own_q);
        end
      end else begin
        // Owner went idle: release and let round-robin handle this cycle.
        lock_act_d = 1'b0;
        lock_cnt_d = '0;
        ptr_d      = next_idx(lock_own_q);
      end
    end
    if (lock_free && accept) begin
      if (req_lock[win] && (MAX_LOCK > 1)) begin
        lock_act_d = 1'b1;
        lock_own_d = win;
        lock_cnt_d = 8'd1;
      end else begin
        ptr_d = next_idx(win);
      end
    end
`else
    if (accept) begin
      ptr_d = next_idx(win);
    end
`endif
  end

  // Enable, pointer and read-return tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q  <= 1'b0;
      ptr_q <= '0;
      rd_q  <= '0;
    end else begin
      en_q  <= 1'b1;
      ptr_q <= ptr_d;
      rd_q  <= rd_d;
    end
  end

`ifdef AXI_MEM_ARB_LOCK_EN
  // Lock owner state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_act_q <= 1'b0;
      lock_own_q <= '0;
      lock_cnt_q <= '0;
    end else begin
      lock_act_q <= lock_act_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`endif

  assign rsp_valid = rd_q;
  assign rsp_rdata = mem_rdata;

endmodule
